// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: W-bit ripple-carry adder with registered sum, carry-out and signed overflow
module ripple_carry_adder #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         ov
);
  logic [W:0]   c;
  logic [W-1:0] sum;
  // one full-adder cell per bit; the carry is evaluated cell by cell in bit order
  always_comb begin
    c = {{W{1'b0}}, ci};
    sum = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end
  always_ff @(posedge clk) begin
    s <= rst ? '0 : sum;
    co <= rst ? 1'b0 : c[W];
    ov <= rst ? 1'b0 : c[W] ^ c[W-1];
  end
endmodule

// File: tb/tb_ripple_carry_adder.sv
// tb_ripple_carry_adder: directed checks of the registered ripple adder at W=4, W=1 and W=16
module tb_ripple_carry_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] a4 = '0, b4 = '0, s4;
  logic ci4 = 1'b0, co4, ov4;
  logic a1 = 1'b0, b1 = 1'b0, ci1 = 1'b0, s1, co1, ov1;
  logic [15:0] a16 = '0, b16 = '0, s16;
  logic ci16 = 1'b0, co16, ov16;
  int total = 0;
  int bad = 0;
  logic [2:0] exp1 [8] = '{3'b000, 3'b101, 3'b001, 3'b010, 3'b001, 3'b010, 3'b110, 3'b011};

  always #5 clk = ~clk;

  ripple_carry_adder #(.W(4)) d4 (.clk(clk), .rst(rst), .a(a4), .b(b4), .ci(ci4), .s(s4), .co(co4), .ov(ov4));
  ripple_carry_adder #(.W(1)) d1 (.clk(clk), .rst(rst), .a(a1), .b(b1), .ci(ci1), .s(s1), .co(co1), .ov(ov1));
  ripple_carry_adder #(.W(16)) d16 (.clk(clk), .rst(rst), .a(a16), .b(b16), .ci(ci16), .s(s16), .co(co16), .ov(ov16));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic v4(input string tag, input logic [3:0] a, input logic [3:0] b, input logic ci, input logic [5:0] exp);
    a4 = a;
    b4 = b;
    ci4 = ci;
    step();
    chk(tag, {ov4, co4, s4}, exp);
  endtask

  task automatic v16(input string tag, input logic [15:0] a, input logic [15:0] b, input logic ci, input logic [17:0] exp);
    a16 = a;
    b16 = b;
    ci16 = ci;
    step();
    chk(tag, {ov16, co16, s16}, exp);
  endtask

  initial begin
    a4 = 4'hf;
    b4 = 4'hf;
    a16 = 16'hffff;
    b16 = 16'hffff;
    a1 = 1'b1;
    b1 = 1'b1;
    step();
    chk("rst4", {ov4, co4, s4}, 0);
    chk("rst1", {ov1, co1, s1}, 0);
    chk("rst16", {ov16, co16, s16}, 0);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      a4 = 4'(i % 16);
      b4 = 4'(i / 16);
      ci4 = 1'b0;
      step();
      chk($sformatf("exh%0d", i), {co4, s4}, i % 16 + i / 16);
    end
    v4("ex9p7", 4'b1001, 4'b0111, 1'b0, 6'b010000);
    v4("cin_ff", 4'b1111, 4'b1111, 1'b1, 6'b011111);
    v4("cin_00", 4'b0000, 4'b0000, 1'b1, 6'b000001);
    v4("ripple", 4'b1111, 4'b0000, 1'b1, 6'b010000);
    v4("ov_7p1", 4'b0111, 4'b0001, 1'b0, 6'b101000);
    v4("ov_8p8", 4'b1000, 4'b1000, 1'b0, 6'b110000);
    v4("nov_fp1", 4'b1111, 4'b0001, 1'b0, 6'b010000);
    a4 = 4'b1111;
    b4 = 4'b1111;
    ci4 = 1'b0;
    rst = 1'b1;
    step();
    chk("midrst1", {ov4, co4, s4}, 0);
    step();
    chk("midrst2", {ov4, co4, s4}, 0);
    rst = 1'b0;
    step();
    chk("release", {ov4, co4, s4}, 6'b011110);
    for (int i = 0; i < 8; i++) begin
      {a1, b1, ci1} = 3'(i);
      step();
      chk($sformatf("w1_%0d", i), {ov1, co1, s1}, exp1[i]);
    end
    v16("w16_wrap", 16'hffff, 16'h0001, 1'b0, 18'h10000);
    v16("w16_ovp", 16'h7fff, 16'h0001, 1'b0, 18'h28000);
    v16("w16_ovn", 16'h8000, 16'h8000, 1'b0, 18'h30000);
    v16("w16_mix", 16'h1234, 16'h4321, 1'b1, 18'h05556);
    v16("w16_max", 16'hffff, 16'hffff, 1'b1, 18'h1ffff);
    for (int i = 0; i < 1000; i++) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      ci16 = 1'($urandom);
      step();
      chk("w16_rand", {co16, s16}, 32'(a16) + 32'(b16) + 32'(ci16));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
